// File: rtl/pipe_credit_rx.sv
// pipe_credit_rx: result FIFO behind a fixed-latency delay line, with credit gating of new issues.
// Optional same-cycle bypass when PIPE_CREDIT_RX_BYPASS_EN is defined.
module pipe_credit_rx #(
  parameter  int N     = 3,
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  output logic [CW-1:0]    o_credits,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic             o_overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  if (DEPTH < 1 || N < 1) begin : g_param_check
    $error("pipe_credit_rx: DEPTH and N must both be at least 1");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_credits;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_bypass_take;
  logic w_issue_fire;
  logic w_out_fire;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

`ifdef PIPE_CREDIT_RX_BYPASS_EN
  assign w_bypass = w_empty && i_in_valid;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_take = w_bypass && i_out_ready;

  assign o_out_valid   = !w_empty || w_bypass;
  assign o_out_data    = w_bypass ? i_in_data : r_mem[r_rd_ptr];
  assign o_issue_ready = (r_credits != '0);
  assign o_credits     = r_credits;
  assign o_overflow    = r_overflow;

  assign w_issue_fire = i_issue_valid && o_issue_ready;
  assign w_out_fire   = o_out_valid && i_out_ready;

  // A read frees the head slot in the same cycle, so a write at full is still legal then.
  assign w_rd   = w_out_fire && !w_empty;
  assign w_wr   = i_in_valid && !w_bypass_take && (!w_full || w_rd);
  assign w_drop = i_in_valid && w_full && !w_rd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + PW'(1);
      end
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Credits saturate at DEPTH so stray unissued arrivals cannot wrap the counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_credits <= DEPTH_C;
    end else if (w_issue_fire && !w_out_fire) begin
      r_credits <= r_credits - CW'(1);
    end else if (w_out_fire && !w_issue_fire && (r_credits != DEPTH_C)) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Self-checking bench for pipe_credit_rx: directed scenarios plus randomized traffic vs a queue model.
module tb_pipe_credit_rx;
  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef PIPE_CREDIT_RX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic             issue_ready;
  logic [CW-1:0]    credits;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             overflow;

  always #5 clk = ~clk;

  pipe_credit_rx #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_issue_valid(issue_valid), .o_issue_ready(issue_ready), .o_credits(credits),
    .i_in_valid(in_valid), .i_in_data(in_data),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_overflow(overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of held results, credit integer, sticky overflow, upstream delay line.
  logic [WIDTH-1:0] m_q[$];
  int               m_cred;
  bit               m_ovf;
  bit               dl_v [N];
  logic [WIDTH-1:0] dl_d [N];
  bit               use_dl;
  logic [WIDTH-1:0] issue_data;

  function automatic bit m_valid();
    return (m_q.size() != 0) || (BYP && in_valid);
  endfunction

  function automatic logic [WIDTH-1:0] m_data();
    if (m_q.size() != 0) return m_q[0];
    return in_data;
  endfunction

  task automatic tick();
    bit iss, ofire, take;
    iss   = issue_valid && (m_cred > 0);
    ofire = m_valid() && out_ready;
    take  = BYP && (m_q.size() == 0) && in_valid && out_ready;
    m_cred = m_cred - int'(iss) + int'(ofire);
    if (m_cred > DEPTH) m_cred = DEPTH;
    if ((m_q.size() != 0) && out_ready) void'(m_q.pop_front());
    if (in_valid && !take) begin
      if (m_q.size() < DEPTH) m_q.push_back(in_data);
      else m_ovf = 1'b1;
    end
    for (int i = N - 1; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_d[i] = dl_d[i-1];
    end
    dl_v[0] = iss;
    dl_d[0] = issue_data;
    @(posedge clk);
    #1;
    if (use_dl) begin
      in_valid = dl_v[N-1];
      in_data  = dl_d[N-1];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_valid = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; issue_data = '0;
    use_dl = 1'b0;
    m_q.delete();
    m_cred = DEPTH;
    m_ovf  = 1'b0;
    for (int i = 0; i < N; i++) begin
      dl_v[i] = 1'b0;
      dl_d[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (credits !== CW'(DEPTH)) $display("FAIL reset_credits got=%0d exp=%0d", credits, DEPTH); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp_d;
    do_reset();
    use_dl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      issue_data  = 8'(8'h11 * (i + 1));
      #1;
      n_chk++; if (credits !== CW'(4 - i)) $display("FAIL fill_credits i=%0d got=%0d exp=%0d", i, credits, 4 - i); else n_pass++;
      n_chk++; if (out_valid !== m_valid()) $display("FAIL fill_early_valid i=%0d got=%b exp=%b", i, out_valid, m_valid()); else n_pass++;
      tick();
    end
    issue_valid = 1'b0;
    #1;
    n_chk++; if (credits !== CW'(0)) $display("FAIL fill_credits_zero got=%0d exp=0", credits); else n_pass++;
    n_chk++; if (issue_ready !== 1'b0) $display("FAIL fill_issue_ready got=%b exp=0", issue_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL fill_hold_valid c=%0d got=%b exp=1", c, out_valid); else n_pass++;
      n_chk++; if (out_data !== 8'h11) $display("FAIL fill_hold_data c=%0d got=%h exp=11", c, out_data); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'(8'h11 * (k + 1));
      #1;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL drain_valid k=%0d got=%b exp=1", k, out_valid); else n_pass++;
      n_chk++; if (out_data !== exp_d) $display("FAIL drain_data k=%0d got=%h exp=%h", k, out_data, exp_d); else n_pass++;
      n_chk++; if (credits !== CW'(k)) $display("FAIL drain_credits k=%0d got=%0d exp=%0d", k, credits, k); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (credits !== CW'(DEPTH)) $display("FAIL drain_credits_full got=%0d exp=%0d", credits, DEPTH); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] exp_q [4];
    exp_q[0] = 8'hC1; exp_q[1] = 8'hC2; exp_q[2] = 8'hC3; exp_q[3] = 8'h55;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid    = 1'b1;
      in_data     = 8'(8'hC0 + i);
      issue_valid = (i < 3);
      tick();
    end
    in_valid = 1'b0; issue_valid = 1'b0;
    #1;
    n_chk++; if (credits !== CW'(1)) $display("FAIL simul_pre_credits got=%0d exp=1", credits); else n_pass++;
    issue_valid = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    n_chk++; if (out_data !== 8'hC0) $display("FAIL simul_head got=%h exp=c0", out_data); else n_pass++;
    tick();
    issue_valid = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    n_chk++; if (credits !== CW'(1)) $display("FAIL simul_credits got=%0d exp=1", credits); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL simul_overflow got=%b exp=0", overflow); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL simul_drain_valid k=%0d got=%b exp=1", k, out_valid); else n_pass++;
      n_chk++; if (out_data !== exp_q[k]) $display("FAIL simul_drain_data k=%0d got=%h exp=%h", k, out_data, exp_q[k]); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL simul_empty got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (credits !== CW'(m_cred)) $display("FAIL simul_end_credits got=%0d exp=%0d", credits, m_cred); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      tick();
    end
    in_data = 8'h99;
    #1;
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_before got=%b exp=0", overflow); else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky c=%0d got=%b exp=1", c, overflow); else n_pass++;
      n_chk++; if (out_data !== 8'hA0) $display("FAIL ovf_head c=%0d got=%h exp=a0", c, out_data); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (out_data !== 8'(8'hA0 + k)) $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, out_data, 8'(8'hA0 + k)); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ovf_no_99 got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_still_set got=%b exp=1", overflow); else n_pass++;
    do_reset();
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_reset_clear got=%b exp=0", overflow); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    n_chk++; if (out_valid !== m_valid()) $display("FAIL byp_same_valid got=%b exp=%b", out_valid, m_valid()); else n_pass++;
    if (m_valid()) begin
      n_chk++; if (out_data !== 8'hA5) $display("FAIL byp_same_data got=%h exp=a5", out_data); else n_pass++;
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_chk++; if (out_valid !== m_valid()) $display("FAIL byp_next_valid got=%b exp=%b", out_valid, m_valid()); else n_pass++;
    if (m_valid()) begin
      n_chk++; if (out_data !== 8'hA5) $display("FAIL byp_next_data got=%h exp=a5", out_data); else n_pass++;
    end
    n_chk++; if (credits !== CW'(m_cred)) $display("FAIL byp_credits got=%0d exp=%0d", credits, m_cred); else n_pass++;
    tick();
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL byp_final_empty got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    use_dl = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_data  = 8'($urandom);
      out_ready   = ($urandom_range(0, 9) < ((cyc < 200) ? 3 : 8));
      #1;
      n_chk++; if (credits !== CW'(m_cred)) $display("FAIL rand_credits cyc=%0d got=%0d exp=%0d", cyc, credits, m_cred); else n_pass++;
      n_chk++; if (issue_ready !== (m_cred != 0)) $display("FAIL rand_issue_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, m_cred != 0); else n_pass++;
      n_chk++; if (out_valid !== m_valid()) $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid()); else n_pass++;
      if (m_valid()) begin
        n_chk++; if (out_data !== m_data()) $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, out_data, m_data()); else n_pass++;
      end
      n_chk++; if (overflow !== m_ovf) $display("FAIL rand_overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf); else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    use_dl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_data  = 8'(8'h61 + i);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    tick();
    #1;
    n_chk++; if (credits !== CW'(1)) $display("FAIL mid_pre_credits got=%0d exp=1", credits); else n_pass++;
    n_chk++; if (m_q.size() != 2 || out_data !== 8'h61) $display("FAIL mid_pre_head got=%h exp=61 held=%0d", out_data, m_q.size()); else n_pass++;
    reset = 1'b1; in_valid = 1'b0; use_dl = 1'b0;
    #1;
    n_chk++; if (credits !== CW'(DEPTH)) $display("FAIL mid_credits got=%0d exp=%0d", credits, DEPTH); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL mid_issue_ready got=%b exp=1", issue_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL mid_overflow got=%b exp=0", overflow); else n_pass++;
    do_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_after_release got=%b exp=0", out_valid); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; issue_data = '0;
    use_dl = 1'b0;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_overflow();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
